// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader
//   Accepts decoded instruction fields over a valid/ready handshake, encodes
//   each one into a 16-bit instruction word, and writes it to instruction
//   memory at consecutive addresses starting from 0.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               open a load session (ignored while loading)
//   in_valid/in_ready   field handshake; a transfer happens when both are high
//   mnem,rs,rt,rd,imm   instruction fields (mnem 0..16 legal, 17..31 illegal)
//   mem_we/addr/wdata   registered one-cycle write port to instruction memory
//   words               words written during the current session
//   busy, done          session in progress / session ended on HALT
//   err                 00 ok, 01 illegal mnem, 10 memory full before HALT
module inst_encoder_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [2:0]        rs,
  input  logic [2:0]        rt,
  input  logic [2:0]        rd,
  input  logic [5:0]        imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   words,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W:0]     r_words;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [1:0]          r_err;

  logic                w_legal, w_halt, w_accept, w_restart, w_last;
  logic [15:0]         w_enc;

  // Encoder: pure function of the current fields
  always_comb begin
    w_legal = 1'b1;
    w_halt  = 1'b0;
    w_enc   = 16'h0000;
    case (mnem)
      5'd0, 5'd1, 5'd5, 5'd6: w_enc = {4'b1111, rs, rt,     rd, mnem[2:0]};
      5'd2, 5'd3, 5'd4:       w_enc = {4'b1111, rs, 3'b000, rd, mnem[2:0]};
      5'd7:  w_enc = {4'b0010, rs, rt, imm};
      5'd8:  w_enc = {4'b0100, rs, rt, imm};
      5'd9:  w_enc = {4'b0101, rs, rt, imm};
      5'd10: w_enc = {4'b0110, rs, rt, imm};
      5'd11: w_enc = {4'b0111, rs, rt, imm};
      5'd12: w_enc = {4'b1000, rs, rt, imm};
      5'd13: w_enc = {4'b1001, rs, rt, imm};
      5'd14: w_enc = {4'b1010, rs, 3'b000, imm};
      5'd15: w_enc = {4'b1011, rs, 3'b000, imm};
      5'd16: begin w_enc = 16'h0001; w_halt = 1'b1; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_accept  = in_valid && (r_state == S_LOAD);
  assign w_restart = start && (r_state != S_LOAD);
  assign w_last    = (r_cnt == {ADDR_W{1'b1}});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (!w_legal)    w_state_nxt = S_ERR;
          else if (w_halt) w_state_nxt = S_DONE;
          else if (w_last) w_state_nxt = S_ERR;
        end
      end
      default: if (start) w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= 1'b0;
      if (w_restart) begin
        r_cnt   <= '0;
        r_words <= '0;
        r_err   <= 2'b00;
      end else if (w_accept) begin
        if (!w_legal) begin
          r_err <= 2'b01;
        end else begin
          r_we    <= 1'b1;
          r_addr  <= r_cnt;
          r_wdata <= w_enc;
          r_cnt   <= r_cnt + ADDR_W'(1);
          r_words <= r_words + (ADDR_W+1)'(1);
          // HALT into the last slot is a clean finish, not an overflow
          if (!w_halt && w_last) r_err <= 2'b10;
        end
      end
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign busy      = (r_state == S_LOAD);
  assign done      = (r_state == S_DONE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign words     = r_words;
  assign err       = r_err;

endmodule

// File: doc/inst_encoder_loader.md
INST_ENCODER_LOADER -- requirements
Module: inst_encoder_loader

Interface
REQ-001 The parameter shall be ADDR_W, default 6, meaning the instruction-memory address width; DEPTH = 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  begin a load session at address 0.
REQ-005 in_valid  input  1  instruction fields are valid.
REQ-006 in_ready  output  1  block accepts fields; transfer occurs when in_valid && in_ready at a clock edge.
REQ-007 mnem  input  5  operation code: 0 ADD, 1 SUB, 2 SRA, 3 SRL, 4 SLL, 5 AND, 6 OR, 7 LB, 8 SB, 9 ADDI, 10 ANDI, 11 ORI, 12 BEQ, 13 BNE, 14 BGEZ, 15 BLTZ, 16 HALT; 17-31 illegal.
REQ-008 rs, rt, rd  input  3 each  register fields.
REQ-009 imm  input  6  immediate or branch offset.
REQ-010 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  write address.
REQ-012 mem_wdata  output  16  encoded instruction word.
REQ-013 words  output  ADDR_W+1  count of words written this session.
REQ-014 busy, done  output  1 each  session in progress / session ended with HALT.
REQ-015 err  output  2  00 none, 01 illegal mnem, 10 memory full without HALT.

Function
REQ-016 The word format shall be [15:12] OP, [11:9] RS, [8:6] RT, [5:3] RD, [2:0] FUNCT; I-type and branch formats use [5:0] for imm.
REQ-017 R-type (mnem 0-6) shall encode OP=1111, RS=rs, RD=rd, FUNCT=mnem[2:0], and RT=rt for ADD/SUB/AND/OR or RT=000 for SRA/SRL/SLL.
REQ-018 I-type shall encode OP 0010 LB, 0100 SB, 0101 ADDI, 0110 ANDI, 0111 ORI, with RS=rs, RT=rt, [5:0]=imm.
REQ-019 Branches shall encode OP 1000 BEQ, 1001 BNE, 1010 BGEZ, 1011 BLTZ, with RS=rs, [5:0]=imm, and RT=rt for BEQ/BNE or RT=000 for BGEZ/BLTZ.
REQ-020 HALT shall encode as 16'h0001.
REQ-021 The FSM shall have states IDLE, LOAD, DONE and ERR; in_ready = (state==LOAD), busy = (state==LOAD), done = (state==DONE).
REQ-022 In IDLE, DONE or ERR, start shall go to LOAD, clear the address counter and words, and set err=00; start in LOAD shall be ignored.
REQ-023 A legal transfer in LOAD shall, on the same edge, register mem_wdata=encoding, mem_addr=counter and mem_we=1, then increment the counter and words.
REQ-024 Write latency shall be exactly one cycle after acceptance, mem_we shall be high for one cycle per transfer, and back-to-back transfers shall be supported.
REQ-025 An accepted HALT shall be written, and on the same edge the FSM shall go to DONE.
REQ-026 An accepted legal non-HALT at counter==DEPTH-1 shall be written, and on the same edge the FSM shall go to ERR with err=10.
REQ-027 An accepted illegal mnem shall produce no write, leave the counter unchanged, and go to ERR with err=01.
REQ-028 mem_addr and mem_wdata shall hold their last values when mem_we=0.
REQ-029 in_valid outside LOAD shall be ignored.

Reset
REQ-030 rst shall force immediately, regardless of clk: state IDLE, counter 0, words 0, mem_we 0, mem_addr 0, mem_wdata 0, err 00, in_ready 0, busy 0, done 0.
REQ-031 rst mid-session shall abort the session; a write strobe that was pending shall be dropped.

Verification
REQ-032 Reset, start, then ADD rs=2 rt=3 rd=1 -> next cycle mem_we=1, mem_addr=0, mem_wdata=16'hF4C8, words=1.
REQ-033 Back-to-back ADDI rs=1 rt=2 imm=5, then SLL rs=4 rt=7 rd=5 -> 16'h5285 at addr 1, then 16'hF82C at addr 2 (RT forced to 0).
REQ-034 BLTZ rs=3 rt=5 imm=0x3E, then HALT -> 16'hB63E, then 16'h0001; done=1 and in_ready=0 from the cycle after HALT acceptance.
REQ-035 mnem=20 in LOAD -> no mem_we, err=01, words unchanged; a later start -> LOAD with err=00 and words=0.
REQ-036 With ADDR_W=6, 64 ADD transfers -> 64 writes at addrs 0-63, err=10 after the last one, words=64.
REQ-037 rst asserted between clock edges the cycle after an acceptance -> outputs zero immediately, mem_we never asserts, state IDLE.
